// File: rtl/btn_input_port.sv
// btn_input_port: synchronized, debounced push-button port with sticky press/release
// flags, a press counter and a press interrupt, read over a one-cycle-latency bus.
module btn_input_port #(
  parameter int NUM_BTN         = 7,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic               clk_25mhz,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               rd_en,
  input  logic [1:0]         rd_addr,
  output logic [31:0]        rd_data,
  output logic               rd_valid,
  output logic               irq
);
  logic [NUM_BTN-1:0] sync1_q, sync2_q, stable_q, stable_d, prev_q;
  logic [NUM_BTN-1:0] press_q, press_d, rel_q, rel_d, rise, fall;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];
  logic [15:0]        press_count_q, press_count_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               rd_valid_q, irq_q;
  logic [4:0]         n_rise;
  logic               clr_press, clr_rel;
  always_comb begin
    rise      = stable_q & ~prev_q;
    fall      = ~stable_q & prev_q;
    n_rise    = '0;
    stable_d  = stable_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      n_rise   = n_rise + 5'(rise[i]);
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    press_count_d = press_count_q + 16'(n_rise);
    clr_press     = rd_en && rd_addr == 2'd1;
    clr_rel       = rd_en && rd_addr == 2'd2;
    // a new event in the clearing cycle survives: set wins over clear
    press_d   = (press_q & ~{NUM_BTN{clr_press}}) | rise;
    rel_d     = (rel_q & ~{NUM_BTN{clr_rel}}) | fall;
    rd_data_d = !rd_en           ? rd_data_q :
                rd_addr == 2'd0 ? 32'(stable_q) :
                rd_addr == 2'd1 ? 32'(press_q) :
                rd_addr == 2'd2 ? 32'(rel_q) : {16'b0, press_count_q};
  end
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      prev_q        <= '0;
      cnt_q         <= '{default: '0};
      press_q       <= '0;
      rel_q         <= '0;
      press_count_q <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      sync1_q       <= btn;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      prev_q        <= stable_q;
      cnt_q         <= cnt_d;
      press_q       <= press_d;
      rel_q         <= rel_d;
      press_count_q <= press_count_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_en;
      irq_q         <= |press_q;
    end
  end
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;
endmodule
